pipe_stall_ctrl: RTL

//  Central pipeline controller for the MiniMIPS32 core. Merges stall requests from ID (load-use), EXE
//  (multi-cycle divide) and MEM (bus wait) into the `STALL_BUS vector consumed by the PC, IF/ID, ID/EXE,
//  EXE/MEM and MEM/WB pipeline registers. Sequences the divider through a cycle counter. Converts a MEM-stage

---
 rtl/pipe_stall_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Merges ID/EXE/MEM stall requests into the 5-bit stall vector, runs the divide counter FSM and
// turns a MEM exception into a one-cycle registered flush plus PC redirect (stall is combinational).
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        stallreq_mem,
  input  logic        exc_req,
  input  logic [31:0] exc_handler_pc,
  output logic [4:0]  stall,
  output logic        flush,
  output logic        redirect_en,
  output logic [31:0] redirect_pc,
  output logic        div_busy,
  output logic        div_done
);

  localparam int                CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [31:0]       PC_INIT  = 32'hBFC00000;

  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_ALL  = 5'b11111;
  localparam logic [4:0] STALL_EXE  = 5'b01111;
  localparam logic [4:0] STALL_ID   = 5'b00111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             exc_take;

  // The MEM stage is squashed during the flush cycle, so a request seen then is not real.
  assign exc_take = exc_req && !flush;

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (exc_take) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start && !flush) begin
            state_nxt = DIV_RUN;
            cnt_nxt   = CNT_LOAD;
          end
        end
        DIV_RUN: begin
          // The divider keeps counting even while MEM freezes the pipe.
          if (cnt == '0) state_nxt = DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        DONE: begin
          // div_start is ignored here so the same instruction cannot restart.
          if (!stallreq_mem) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    div_busy = (state == DIV_RUN);
    div_done = (state == DONE);
    stall    = STALL_NONE;
    if (!cpu_rst_n || flush)          stall = STALL_NONE;
    else if (exc_req || stallreq_mem) stall = STALL_ALL;
    else if (state == DIV_RUN)        stall = STALL_EXE;
    else if (stallreq_id)             stall = STALL_ID;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      flush       <= 1'b0;
      redirect_en <= 1'b0;
      redirect_pc <= PC_INIT;
    end else begin
      flush       <= exc_take;
      redirect_en <= exc_take;
      if (exc_take) redirect_pc <= exc_handler_pc;
    end
  end

endmodule
